// File: rtl/sparc_ram_responder.sv
// Memory-side responder for the RAM_enable/RAM_OpCode/MFC handshake: byte-addressed,
// big-endian data memory performing SPARC V8 load/store widths with alignment checks.
module sparc_ram_responder #(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_STATES = 2
) (
   input  logic        Clk,
   input  logic        RESET,
   input  logic        RAM_enable,
   input  logic [5:0]  RAM_OpCode,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        MFC,
   output logic        MAE
);
   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state_reg;
   logic [3:0]              count_reg;
   logic [5:0]              op_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [31:0]             data_reg;

   logic                    legal, is_load, is_store, is_signed;
   logic                    size_byte, size_half, size_word;
   logic                    acc_err, access_now;
   logic [IDX_W-1:0]        rd_idx;
   logic [31:0]             rd_word;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [31:0]             load_val;

   logic                    unused_addr_bits;
   assign unused_addr_bits = ^address[31:ADDR_WIDTH];

   always_comb begin
      legal     = 1'b1;
      is_load   = 1'b0;
      is_store  = 1'b0;
      size_byte = 1'b0;
      size_half = 1'b0;
      size_word = 1'b0;
      case (op_reg)
         6'b000000: begin is_load  = 1'b1; size_word = 1'b1; end
         6'b000001: begin is_load  = 1'b1; size_byte = 1'b1; end
         6'b000010: begin is_load  = 1'b1; size_half = 1'b1; end
         6'b001001: begin is_load  = 1'b1; size_byte = 1'b1; end
         6'b001010: begin is_load  = 1'b1; size_half = 1'b1; end
         6'b000100: begin is_store = 1'b1; size_word = 1'b1; end
         6'b000101: begin is_store = 1'b1; size_byte = 1'b1; end
         6'b000110: begin is_store = 1'b1; size_half = 1'b1; end
         default:   legal = 1'b0;
      endcase
      is_signed  = op_reg[3];
      acc_err    = !legal || (size_word && addr_reg[1:0] != 2'b00) || (size_half && addr_reg[0]);
      access_now = (state_reg == BUSY) && (count_reg == 4'd0) && !RESET;
   end

   // While idle, read at the incoming address so the word is ready even with no wait states.
   assign rd_idx = (state_reg == IDLE) ? address[ADDR_WIDTH-1:2] : addr_reg[ADDR_WIDTH-1:2];

   // Four byte lanes; lane 0 holds the most significant (lowest-addressed) byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic [7:0] mem_lane [DEPTH];
         logic [7:0] rd_q;
         logic [7:0] wr_byte;
         logic       wr_en;

         always_comb begin
            wr_byte = data_reg[7:0];
            if (size_word)
               wr_byte = data_reg[31-8*gi -: 8];
            else if (size_half && !LANE[0])
               wr_byte = data_reg[15:8];
            wr_en = access_now && is_store && !acc_err &&
                    (size_word || (size_half && addr_reg[1] == LANE[1]) ||
                     (size_byte && addr_reg[1:0] == LANE));
         end

         always_ff @(posedge Clk) begin
            if (wr_en)
               mem_lane[addr_reg[ADDR_WIDTH-1:2]] <= wr_byte;
            rd_q <= mem_lane[rd_idx];
         end

         assign rd_word[31-8*gi -: 8] = rd_q;
      end
   endgenerate

   always_comb begin
      case (addr_reg[1:0])
         2'd0:    byte_sel = rd_word[31:24];
         2'd1:    byte_sel = rd_word[23:16];
         2'd2:    byte_sel = rd_word[15:8];
         default: byte_sel = rd_word[7:0];
      endcase
      half_sel = addr_reg[1] ? rd_word[15:0] : rd_word[31:16];
      if (size_word)
         load_val = rd_word;
      else if (size_half)
         load_val = {{16{is_signed & half_sel[15]}}, half_sel};
      else
         load_val = {{24{is_signed & byte_sel[7]}}, byte_sel};
   end

   always_ff @(posedge Clk) begin
      if (RESET) begin
         state_reg <= IDLE;
         count_reg <= 4'd0;
         op_reg    <= 6'd0;
         addr_reg  <= '0;
         data_reg  <= 32'd0;
         data_out  <= 32'd0;
         MFC       <= 1'b0;
         MAE       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (RAM_enable) begin
               op_reg    <= RAM_OpCode;
               addr_reg  <= address[ADDR_WIDTH-1:0];
               data_reg  <= data_in;
               count_reg <= 4'(WAIT_STATES);
               state_reg <= BUSY;
            end
            BUSY: if (count_reg != 4'd0) begin
               count_reg <= count_reg - 4'd1;
            end else begin
               MFC <= 1'b1;
               MAE <= acc_err;
               if (is_load && !acc_err)
                  data_out <= load_val;
               state_reg <= DONE;
            end
            DONE: if (!RAM_enable) begin
               MFC       <= 1'b0;
               MAE       <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule
